// File: rtl/markov_pkg.sv
// markov_pkg: shared widths, FSM states and LFSR constants for the Markov sampler and table learner.
package markov_pkg;
  localparam int TOKEN_W_DEF = 8;
  localparam int COUNT_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  typedef enum logic [2:0] {IDLE, SUM, DRAW, PICK, FINISH} state_e;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/markov_lfsr16.sv
// markov_lfsr16: 16-bit Fibonacci LFSR; a zero seed maps to the default seed so it never locks up.
module markov_lfsr16 import markov_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);
  logic [15:0] value_q, value_d;
  always_comb value_d = load ? ((seed == '0) ? LFSR_SEED : seed) : step ? lfsr_next(value_q) : value_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) value_q <= LFSR_SEED;
    else value_q <= value_d;
  assign value = value_q;
endmodule

// File: rtl/markov_sampler.sv
// markov_sampler: predicts the next token from a transition table, greedily (max count) or by weighted random draw.
module markov_sampler import markov_pkg::*; #(
  parameter int TOKEN_W = TOKEN_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [TOKEN_W-1:0] cur_token,
  input  logic [ADDR_W:0]    list_len,
  input  logic               greedy,
  input  logic               seed_load,
  input  logic [15:0]        seed,
  output logic [ADDR_W-1:0]  tbl_addr,
  input  logic [TOKEN_W-1:0] tbl_from,
  input  logic [TOKEN_W-1:0] tbl_to,
  input  logic [COUNT_W-1:0] tbl_count,
  output logic               busy,
  output logic               done,
  output logic               valid,
  output logic [TOKEN_W-1:0] next_token
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int LW = ADDR_W + 1;
  localparam int SW = COUNT_W + ADDR_W + 1;
  localparam int PW = SW + 16;
  state_e state_q, state_d;
  logic [TOKEN_W-1:0] tok_q, tok_d, pick_q, pick_d, next_q, next_d;
  logic [LW-1:0] len_q, len_d, cnt_q, cnt_d, len_clamp;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SW-1:0] sum_q, sum_d, acc_q, acc_d, r_q, r_d, amt, sum_add, acc_add;
  logic [COUNT_W-1:0] max_q, max_d;
  logic greedy_q, greedy_d, found_q, found_d, done_q, done_d, valid_q, valid_d;
  logic match, have_data, last, step;
  logic [15:0] lfsr_value;
  logic [PW-1:0] prod;
  markov_lfsr16 u_lfsr (
    .clk  (clk),
    .reset(reset),
    .load (seed_load && state_q == IDLE),
    .seed (seed),
    .step (step),
    .value(lfsr_value)
  );
  assign len_clamp = (list_len > LW'(DEPTH)) ? LW'(DEPTH) : list_len;
  assign match = tbl_from == tok_q;
  assign amt = match ? SW'(tbl_count) : '0;
  assign sum_add = sum_q + amt;
  assign acc_add = acc_q + amt;
  // table data lags the address by one cycle, so cnt_q indexes the entry arriving now plus one
  assign have_data = cnt_q != '0;
  assign last = cnt_q == len_q;
  assign prod = PW'(lfsr_value) * PW'(sum_q);
  always_comb begin
    state_d = state_q;
    tok_d = tok_q;
    len_d = len_q;
    greedy_d = greedy_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    sum_d = sum_q;
    acc_d = acc_q;
    r_d = r_q;
    max_d = max_q;
    pick_d = pick_q;
    found_d = found_q;
    done_d = 1'b0;
    valid_d = valid_q;
    next_d = next_q;
    step = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        tok_d = cur_token;
        len_d = len_clamp;
        greedy_d = greedy;
        valid_d = 1'b0;
        sum_d = '0;
        acc_d = '0;
        max_d = '0;
        pick_d = '0;
        found_d = 1'b0;
        cnt_d = '0;
        addr_d = '0;
        state_d = (len_clamp == '0) ? FINISH : SUM;
      end
      SUM: begin
        cnt_d = cnt_q + 1'b1;
        addr_d = ADDR_W'(cnt_q + 1'b1);
        if (have_data) begin
          sum_d = sum_add;
          if (match && tbl_count > max_q) begin
            max_d = tbl_count;
            pick_d = tbl_to;
          end
        end
        if (last) begin
          cnt_d = '0;
          addr_d = '0;
          found_d = greedy_q && sum_add != '0;
          state_d = (greedy_q || sum_add == '0) ? FINISH : DRAW;
        end
      end
      DRAW: begin
        r_d = SW'(prod >> 16);
        step = 1'b1;
        cnt_d = '0;
        addr_d = '0;
        state_d = PICK;
      end
      PICK: begin
        cnt_d = cnt_q + 1'b1;
        addr_d = ADDR_W'(cnt_q + 1'b1);
        if (have_data) begin
          acc_d = acc_add;
          if (match && acc_add > r_q) begin
            pick_d = tbl_to;
            found_d = 1'b1;
            state_d = FINISH;
          end else if (last) state_d = FINISH;
        end
      end
      FINISH: begin
        done_d = 1'b1;
        valid_d = found_q;
        next_d = found_q ? pick_q : next_q;
        addr_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      tok_q <= '0;
      len_q <= '0;
      greedy_q <= 1'b0;
      cnt_q <= '0;
      addr_q <= '0;
      sum_q <= '0;
      acc_q <= '0;
      r_q <= '0;
      max_q <= '0;
      pick_q <= '0;
      found_q <= 1'b0;
      done_q <= 1'b0;
      valid_q <= 1'b0;
      next_q <= '0;
    end else begin
      state_q <= state_d;
      tok_q <= tok_d;
      len_q <= len_d;
      greedy_q <= greedy_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      sum_q <= sum_d;
      acc_q <= acc_d;
      r_q <= r_d;
      max_q <= max_d;
      pick_q <= pick_d;
      found_q <= found_d;
      done_q <= done_d;
      valid_q <= valid_d;
      next_q <= next_d;
    end
  assign tbl_addr = addr_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign valid = valid_q;
  assign next_token = next_q;
endmodule

// File: tb/tb_markov_sampler.sv
// tb_markov_sampler: scoreboard bench; a reference model predicts each result when start is driven.
module tb_markov_sampler;
  localparam int TW = 8, CW = 8, AW = 4, NE = 16;
  logic clk = 1'b0, reset, start, greedy, seed_load;
  logic [TW-1:0] cur_token, tbl_from, tbl_to, next_token;
  logic [AW:0] list_len;
  logic [15:0] seed;
  logic [AW-1:0] tbl_addr;
  logic [CW-1:0] tbl_count;
  logic busy, done, valid;
  logic [TW-1:0] mf [NE], mt [NE];
  logic [CW-1:0] mc [NE];
  int total = 0, bad = 0;
  logic [15:0] m_lfsr;
  logic [TW-1:0] m_next;
  typedef struct {logic v; logic [TW-1:0] tok; int lat; int bound;} exp_t;
  exp_t sb [$];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    tbl_from <= mf[tbl_addr];
    tbl_to <= mt[tbl_addr];
    tbl_count <= mc[tbl_addr];
  end
  markov_sampler dut (
    .clk(clk), .reset(reset), .start(start), .cur_token(cur_token), .list_len(list_len),
    .greedy(greedy), .seed_load(seed_load), .seed(seed), .tbl_addr(tbl_addr),
    .tbl_from(tbl_from), .tbl_to(tbl_to), .tbl_count(tbl_count), .busy(busy),
    .done(done), .valid(valid), .next_token(next_token)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] step16(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction
  task automatic clear_tbl();
    for (int i = 0; i < NE; i++) begin
      mf[i] = '0;
      mt[i] = '0;
      mc[i] = '0;
    end
  endtask
  task automatic load_seed(input logic [15:0] s);
    @(negedge clk);
    seed = s;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr = (s == 16'h0) ? 16'hACE1 : s;
  endtask
  task automatic predict(input logic [TW-1:0] tok, input int len, input logic g, output exp_t e);
    int n, sum, mx, acc;
    longint r;
    logic hit;
    logic [TW-1:0] best, pk;
    n = (len > NE) ? NE : len;
    sum = 0; mx = 0; acc = 0; hit = 0; best = '0; pk = '0;
    for (int i = 0; i < n; i++)
      if (mf[i] == tok) begin
        sum += int'(mc[i]);
        if (int'(mc[i]) > mx) begin
          mx = int'(mc[i]);
          best = mt[i];
        end
      end
    e.v = sum != 0;
    e.tok = m_next;
    e.lat = (n == 0) ? 2 : (g || sum == 0) ? n + 3 : 0;
    e.bound = 2 * n + 6;
    if (sum != 0) begin
      if (g) e.tok = best;
      else begin
        r = (longint'(m_lfsr) * longint'(sum)) >> 16;
        for (int i = 0; i < n; i++)
          if (mf[i] == tok) begin
            acc += int'(mc[i]);
            if (!hit && longint'(acc) > r) begin
              hit = 1'b1;
              pk = mt[i];
            end
          end
        m_lfsr = step16(m_lfsr);
        e.tok = pk;
      end
    end
    m_next = e.tok;
  endtask
  task automatic run(input logic [TW-1:0] tok, input int len, input logic g, input int restart_at);
    exp_t e, got_e;
    int done_at, pulses, limit;
    done_at = 0; pulses = 0;
    limit = 2 * len + 12;
    predict(tok, len, g, e);
    sb.push_back(e);
    @(negedge clk);
    cur_token = tok;
    list_len = len[AW:0];
    greedy = g;
    start = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = (k == restart_at);
      if (k == 1) begin
        check("busy_on", busy, 1);
        check("valid_clr", valid, 0);
      end
      if (done) begin
        pulses++;
        if (done_at == 0) begin
          done_at = k;
          got_e = sb.pop_front();
          check("valid", valid, got_e.v);
          check("next", next_token, got_e.tok);
          check("busy_off", busy, 0);
          if (got_e.lat > 0) check("latency", done_at, got_e.lat);
          else check("lat_bound", (done_at <= got_e.bound) ? got_e.bound : done_at, got_e.bound);
        end
      end
    end
    start = 1'b0;
    if (done_at == 0) begin
      check("timeout", 0, 1);
      got_e = sb.pop_front();
    end
    check("pulses", pulses, 1);
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; greedy = 1'b0; seed_load = 1'b0; seed = '0;
    cur_token = '0; list_len = '0;
    m_lfsr = 16'hACE1; m_next = '0;
    clear_tbl();
    #1 reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", valid, 0);
    check("rst_next", next_token, 0);
    check("rst_addr", tbl_addr, 0);
    check("rst_lfsr", dut.lfsr_value, 16'hACE1);
    @(negedge clk);
    reset = 1'b1;
    run(8'd3, 0, 1'b1, 0);
    mf[0] = 3; mt[0] = 7; mc[0] = 2;
    mf[1] = 5; mt[1] = 1; mc[1] = 9;
    mf[2] = 3; mt[2] = 9; mc[2] = 5;
    mf[3] = 3; mt[3] = 4; mc[3] = 5;
    run(8'd3, 4, 1'b1, 0);
    check("greedy_tok", next_token, 9);
    load_seed(16'h0);
    clear_tbl();
    mf[0] = 3; mt[0] = 7; mc[0] = 1;
    mf[1] = 3; mt[1] = 8; mc[1] = 3;
    run(8'd3, 2, 1'b0, 0);
    check("rand_sum", dut.sum_q, 4);
    check("rand_r", dut.r_q, 2);
    check("rand_tok", next_token, 8);
    check("rand_lfsr", dut.lfsr_value, m_lfsr);
    clear_tbl();
    mf[0] = 1; mt[0] = 2; mc[0] = 4;
    run(8'd5, 1, 1'b0, 2);
    check("nomatch_hold", next_token, 8);
    for (int k = 0; k < 6; k++) begin
      load_seed(16'($urandom));
      for (int i = 0; i < NE; i++) begin
        mf[i] = TW'($urandom_range(1, 3));
        mt[i] = TW'($urandom_range(10, 200));
        mc[i] = CW'($urandom_range(0, 15));
      end
      run(8'd2, $urandom_range(1, 20), k[0], 0);
      check("rand_lfsr_loop", dut.lfsr_value, m_lfsr);
    end
    load_seed(16'h1234);
    clear_tbl();
    for (int i = 0; i < 8; i++) begin
      mf[i] = 4; mt[i] = TW'(i + 10); mc[i] = 3;
    end
    @(negedge clk);
    cur_token = 8'd4; list_len = 5'd8; greedy = 1'b0; start = 1'b1;
    repeat (11) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    check("pick_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_valid", valid, 0);
    check("mid_next", next_token, 0);
    check("mid_addr", tbl_addr, 0);
    check("mid_sum", dut.sum_q, 0);
    check("mid_acc", dut.acc_q, 0);
    check("mid_lfsr", dut.lfsr_value, 16'hACE1);
    m_lfsr = 16'hACE1;
    m_next = '0;
    @(negedge clk);
    reset = 1'b1;
    clear_tbl();
    mf[0] = 2; mt[0] = 6; mc[0] = 4;
    run(8'd2, 1, 1'b0, 0);
    check("post_rst_tok", next_token, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/markov_sampler.md
MARKOV_SAMPLER -- requirements
Module: markov_sampler

Interface
REQ-001 SHALL have parameter TOKEN_W, default 8, token width.
REQ-002 SHALL have parameter COUNT_W, default 8, transition count width.
REQ-003 SHALL have parameter ADDR_W, default 4, transition-table address width (DEPTH = 2^ADDR_W entries).
REQ-004 SHALL have port clk, input, 1, clock, with all state on its rising edge.
REQ-005 SHALL have port reset, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, request one next-token prediction.
REQ-007 SHALL have port cur_token, input, TOKEN_W, current token, latched on accepted start.
REQ-008 SHALL have port list_len, input, ADDR_W+1, number of valid table entries, latched on accepted start.
REQ-009 SHALL have port greedy, input, 1, mode select (1 = max-count, 0 = weighted random), latched on accepted start.
REQ-010 SHALL have port seed_load, input, 1, load seed into the LFSR when idle.
REQ-011 SHALL have port seed, input, 16, LFSR seed value.
REQ-012 SHALL have port tbl_addr, output, ADDR_W, table read address.
REQ-013 SHALL have ports tbl_from, tbl_to and tbl_count, input, TOKEN_W/TOKEN_W/COUNT_W, entry fields returned one cycle after tbl_addr is presented.
REQ-014 SHALL have port busy, output, 1, high from the accepted start until done.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port valid, output, 1, a matching transition was found.
REQ-017 SHALL have port next_token, output, TOKEN_W, predicted token.

Function
REQ-018 SHALL accept start only in IDLE; start while busy is ignored.
REQ-019 SHALL clamp latched list_len to DEPTH.
REQ-020 SHALL implement states IDLE, SUM, DRAW, PICK, FINISH.
REQ-021 SHALL, on an accepted start with list_len 0, go IDLE->FINISH and assert done the next cycle with valid=0.
REQ-022 SHALL, in SUM, issue addresses 0..N-1 on consecutive cycles and total the tbl_count of entries whose tbl_from equals cur_token into a sum of width COUNT_W+ADDR_W+1, which cannot overflow.
REQ-023 SHALL, in greedy mode, also track the maximum count during SUM, resolving ties to the lowest index, and then go directly to FINISH; done rises exactly N+3 cycles after the start edge.
REQ-024 SHALL, in random mode with sum>0, compute r = (lfsr * sum) >> 16 in DRAW, giving 0 <= r < sum, and step the LFSR once.
REQ-025 SHALL, in PICK, rescan from address 0, accumulate the matching counts, select the first entry whose accumulated total exceeds r, and terminate on that evaluation.
REQ-026 SHALL treat a zero sum (no match, or only zero-count matches) as valid=0, skip DRAW/PICK, and leave next_token unchanged.
REQ-027 SHALL assert done for exactly one cycle in FINISH, then return to IDLE; valid and next_token hold until the next accepted start, at which point valid clears.
REQ-028 SHALL use a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1, where seed_load in IDLE loads seed and a seed of 0 loads 16'hACE1.
REQ-029 SHALL ignore seed_load while busy.
REQ-030 SHALL bound random-mode latency at 2N+6 cycles from start to done.

Reset
REQ-031 SHALL, on reset low at any time including mid-scan, force IDLE with busy=0, done=0, valid=0, next_token=0, tbl_addr=0, and all accumulators 0.
REQ-032 SHALL reset the LFSR to 16'hACE1.

Structure
REQ-033 SHALL take TOKEN_W, COUNT_W, ADDR_W defaults, the state enum, the LFSR taps and the default seed from shared package markov_pkg, which is also used by the table-building learner.
REQ-034 SHALL place the LFSR in sub-module markov_lfsr16 (ports: clk, reset, load, seed, step, value).

Verification
REQ-035 SHALL check reset with no clock: busy/done/valid/next_token/tbl_addr = 0, and the LFSR = 16'hACE1.
REQ-036 SHALL check start with list_len=0: done pulses 2 cycles later with valid=0.
REQ-037 SHALL check greedy mode with table {(3,7,2),(5,1,9),(3,9,5),(3,4,5)}, cur_token=3: next_token=9, valid=1, done at cycle 7.
REQ-038 SHALL check random mode with seed 0 loaded and table {(3,7,1),(3,8,3)}, cur_token=3: sum=4, r=2, next_token=8, and the LFSR stepped once.
REQ-039 SHALL check table {(1,2,4)} with cur_token=5: valid=0; and a second start during the scan is ignored, with exactly one done pulse.
REQ-040 SHALL check reset pulsed mid-PICK: immediate IDLE and all outputs 0; a following start with table {(2,6,4)}, cur_token=2 returns next_token=6.
